// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU sharing one 64-bit shift register.
// The result lands in HI/LO one edge after FIX, together with the done_o pulse.
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] d_q, rs_q, hi_q, lo_q, res_hi_q, res_lo_q;
  logic [63:0] p_q;
  logic        div_q, nq_q, nr_q, dz_q, wr_q, done_q;
  logic        sgn_d;
  logic [31:0] rs_mag_d, rt_mag_d, fhi_d, flo_d;
  logic [32:0] add_d, sub_d;
  logic [63:0] p_d, prod_d;
  // p_q holds {partial product, multiplier} or {remainder, quotient/dividend}
  always_comb begin
    sgn_d    = ~op_i[0];
    rs_mag_d = (sgn_d && rs_i[31]) ? -rs_i : rs_i;
    rt_mag_d = (sgn_d && rt_i[31]) ? -rt_i : rt_i;
    add_d    = {1'b0, p_q[63:32]} + {1'b0, d_q};
    sub_d    = p_q[63:31] - {1'b0, d_q};
    p_d      = div_q ? (sub_d[32] ? {p_q[62:0], 1'b0} : {sub_d[31:0], p_q[30:0], 1'b1})
                     : (p_q[0] ? {add_d, p_q[31:1]} : {1'b0, p_q[63:1]});
    prod_d   = nq_q ? -p_q : p_q;
    flo_d    = !div_q ? prod_d[31:0]  : dz_q ? '1   : nq_q ? -p_q[31:0]  : p_q[31:0];
    fhi_d    = !div_q ? prod_d[63:32] : dz_q ? rs_q : nr_q ? -p_q[63:32] : p_q[63:32];
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      rs_q     <= '0;
      p_q      <= '0;
      div_q    <= 1'b0;
      nq_q     <= 1'b0;
      nr_q     <= 1'b0;
      dz_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= wr_q;
      wr_q   <= 1'b0;
      if (wr_q) begin
        hi_q <= res_hi_q;
        lo_q <= res_lo_q;
      end else if (state_q == IDLE && !start_i) begin
        if (mthi_i) hi_q <= wdata_i;
        if (mtlo_i) lo_q <= wdata_i;
      end
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q <= ITER;
          cnt_q   <= '0;
          d_q     <= op_i[1] ? rt_mag_d : rs_mag_d;
          p_q     <= {32'd0, op_i[1] ? rs_mag_d : rt_mag_d};
          div_q   <= op_i[1];
          nq_q    <= sgn_d & (rs_i[31] ^ rt_i[31]);
          nr_q    <= sgn_d & rs_i[31];
          dz_q    <= op_i[1] & (rt_i == 32'd0);
          rs_q    <= rs_i;
        end
        ITER: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          res_hi_q <= fhi_d;
          res_lo_q <= flo_d;
          wr_q     <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule
